// File: rtl/alu_tt_pkg.sv
// Shared definitions for the 4-bit ALU tile test driver: FSM encodings,
// ALU op codes and the signature MISR step.
package alu_tt_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_PRESENT = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_RSUB = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_RDIV = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam logic [10:0] LAST_IDX = 11'h7FF;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] MISR_TAPS        = 16'hB400;
    localparam logic [15:0] SIG_SEED_DEFAULT = 16'hFFFF;

    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [7:0] data);
        logic fb;
        fb = ^(sig & MISR_TAPS);
        return {sig[14:0], fb} ^ {8'h00, data};
    endfunction

endpackage

// File: rtl/sig_misr16.sv
// 16-bit multiple-input signature register folding 8-bit results;
// load reseeds and takes priority over enable.
module sig_misr16
    import alu_tt_pkg::*;
#(
    parameter logic [15:0] SEED = SIG_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [7:0]  data_in,
    output logic [15:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (enable) begin
            sig <= misr_step(sig, data_in);
        end
    end

endmodule

// File: rtl/alu_sweep_driver.sv
// Sweeps all 2048 {op,b,a} vectors through a registered ALU slice, streams
// each result over valid/ready and folds it into a MISR signature.
module alu_sweep_driver
    import alu_tt_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1,
    parameter logic [15:0] SIG_SEED    = SIG_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    input  logic [7:0]  alu_result_i,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic [10:0] res_idx,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature
);

    localparam logic [2:0] LAT = 3'(ALU_LATENCY);

    state_t      state;
    logic [10:0] idx;
    logic [2:0]  wait_cnt;
    logic        start_ok;
    logic        sample;

    assign start_ok = !abort && start && (state == ST_IDLE || state == ST_DONE);
    assign sample   = !abort && (state == ST_WAIT) && (wait_cnt == LAT);

    // Abort wins over start and handshake but leaves idx, alu_* and signature alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        idx                    <= '0;
                        {alu_op, alu_b, alu_a} <= '0;
                        done                   <= 1'b0;
                        busy                   <= 1'b1;
                        state                  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= 3'd1;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (sample) begin
                        res_data  <= alu_result_i;
                        res_idx   <= idx;
                        res_valid <= 1'b1;
                        state     <= ST_PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                ST_PRESENT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx                    <= idx + 11'd1;
                            {alu_op, alu_b, alu_a} <= idx + 11'd1;
                            state                  <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sig_misr16 #(
        .SEED(SIG_SEED)
    ) u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (sample),
        .load   (start_ok),
        .data_in(alu_result_i),
        .sig    (signature)
    );

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: two instances (latency 1 and 3) each driving a
// behavioural ALU, checked against an index-ordered result and MISR model.
`timescale 1ns/1ps
module tb_alu_sweep_driver;
    import alu_tt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic res_ready = 1'b1;
    logic sel3 = 1'b0;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] model_sig;
    logic [15:0] sig_ref1;

    logic [2:0]  op1, op3;
    logic [3:0]  a1, b1, a3, b3;
    logic [7:0]  r1, r3;
    logic        v1, v3, busy1, busy3, done1, done3;
    logic [7:0]  d1, d3;
    logic [10:0] i1, i3;
    logic [15:0] s1, s3;
    logic [7:0]  p3 [3];

    logic        o_valid, o_busy, o_done;
    logic [7:0]  o_data;
    logic [10:0] o_idx, o_vec;
    logic [15:0] o_sig;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ai;
        int bi;
        int r;
        ai = int'(a);
        bi = int'(b);
        case (op)
            OP_ADD:  r = ai + bi;
            OP_SUB:  r = ai - bi;
            OP_RSUB: r = bi - ai;
            OP_MUL:  r = ai * bi;
            OP_AND:  r = ai & bi;
            OP_DIV:  r = (bi == 0) ? 255 : ai / bi;
            OP_RDIV: r = (ai == 0) ? 255 : bi / ai;
            default: r = ai | bi;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [7:0] alu_ref(input int k);
        return alu_fn(3'(k / 256), 4'(k % 16), 4'((k / 16) % 16));
    endfunction

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [7:0] d);
        logic [15:0] n;
        n = (s << 1) | 16'(^(s & 16'hB400));
        return n ^ 16'(d);
    endfunction

    // Behavioural registered ALUs, one and three stages deep.
    always @(posedge clk) r1 <= alu_fn(op1, a1, b1);
    always @(posedge clk) begin
        p3[0] <= alu_fn(op3, a3, b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign r3 = p3[2];

    always_comb begin
        o_valid = sel3 ? v3 : v1;
        o_busy  = sel3 ? busy3 : busy1;
        o_done  = sel3 ? done3 : done1;
        o_data  = sel3 ? d3 : d1;
        o_idx   = sel3 ? i3 : i1;
        o_vec   = sel3 ? {op3, b3, a3} : {op1, b1, a1};
        o_sig   = sel3 ? s3 : s1;
    end

    alu_sweep_driver #(.ALU_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel3), .abort(abort),
        .alu_op(op1), .alu_a(a1), .alu_b(b1), .alu_result_i(r1),
        .res_valid(v1), .res_ready(res_ready), .res_data(d1), .res_idx(i1),
        .busy(busy1), .done(done1), .signature(s1)
    );

    alu_sweep_driver #(.ALU_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start & sel3), .abort(abort),
        .alu_op(op3), .alu_a(a3), .alu_b(b3), .alu_result_i(r3),
        .res_valid(v3), .res_ready(res_ready), .res_data(d3), .res_idx(i3),
        .busy(busy3), .done(done3), .signature(s3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One sweep from a start pulse; optional stall, abort or start poke at a given index.
    task automatic applyStimulus(input int lat, input bit rand_ready, input int stall_at,
                                 input int abort_at, input int poke_at);
        int last_cyc;
        int budget;
        model_sig = 16'hFFFF;
        @(negedge clk);
        start = 1'b1;
        res_ready = 1'b1;
        last_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", o_busy, 1);
        checkOutput("done_after_start", o_done, 0);
        for (int k = 0; k < 2048; k++) begin
            budget = 0;
            while (!o_valid && budget < 40) begin
                @(negedge clk);
                budget++;
            end
            if (!o_valid) begin
                checkOutput("result_timeout", 0, 1);
                return;
            end
            checkOutput("res_idx", o_idx, k);
            checkOutput("res_data", o_data, alu_ref(k));
            checkOutput("alu_vec", o_vec, k);
            if (!rand_ready) checkOutput("period", cyc - last_cyc, lat + 2);
            last_cyc = cyc;
            model_sig = misr_ref(model_sig, alu_ref(k));
            checkOutput("signature", o_sig, model_sig);
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checkOutput("abort_valid", o_valid, 0);
                checkOutput("abort_busy", o_busy, 0);
                checkOutput("abort_done", o_done, 0);
                checkOutput("abort_sig_kept", o_sig, model_sig);
                checkOutput("abort_vec_kept", o_vec, k);
                @(negedge clk);
                checkOutput("abort_stays_idle", o_busy, 0);
                return;
            end
            if (k == poke_at) start = 1'b1;
            if (k == stall_at) begin
                res_ready = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    checkOutput("stall_valid", o_valid, 1);
                    checkOutput("stall_idx", o_idx, k);
                    checkOutput("stall_data", o_data, alu_ref(k));
                    checkOutput("stall_vec", o_vec, k);
                    checkOutput("stall_sig", o_sig, model_sig);
                end
                res_ready = 1'b1;
            end else if (rand_ready) begin
                budget = 0;
                res_ready = ($urandom_range(0, 3) != 0);
                while (!res_ready && budget < 20) begin
                    @(negedge clk);
                    checkOutput("bp_valid", o_valid, 1);
                    checkOutput("bp_idx", o_idx, k);
                    budget++;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
            if (k == 2047) checkOutput("done_before_hs", o_done, 0);
            @(negedge clk);
            start = 1'b0;
            checkOutput("valid_after_hs", o_valid, 0);
            if (k == 2047) begin
                checkOutput("done_after_hs", o_done, 1);
                checkOutput("busy_after_done", o_busy, 0);
                checkOutput("final_sig", o_sig, model_sig);
            end else begin
                checkOutput("issue_vec", o_vec, k + 1);
            end
        end
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_valid", o_valid, 0);
        checkOutput("rst_data", o_data, 0);
        checkOutput("rst_idx", o_idx, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_sig", o_sig, 16'hFFFF);
        checkOutput("rst_vec", o_vec, 0);

        applyStimulus(1, 1'b0, -1, -1, -1);
        sig_ref1 = model_sig;

        applyStimulus(1, 1'b1, 100, -1, -1);
        checkOutput("sig_bp_vs_first", o_sig, sig_ref1);

        applyStimulus(1, 1'b0, -1, 500, -1);
        applyStimulus(1, 1'b1, -1, -1, 700);

        // Asynchronous reset while the latency-1 instance sits in WAIT.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_in_wait", o_busy, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", o_valid, 0);
        checkOutput("arst_busy", o_busy, 0);
        checkOutput("arst_done", o_done, 0);
        checkOutput("arst_data", o_data, 0);
        checkOutput("arst_idx", o_idx, 0);
        checkOutput("arst_sig", o_sig, 16'hFFFF);
        checkOutput("arst_vec", o_vec, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sel3 = 1'b1;
        applyStimulus(3, 1'b0, -1, -1, 1000);
        checkOutput("sig_lat3_vs_lat1", o_sig, sig_ref1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
